// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter.
// State encoding is fixed 2-bit binary so it can be decoded in a debugger.
package period_meter_pkg;

  localparam int DEFAULT_CNT_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALLED = 2'd2
  } state_t;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Synchroniser chain plus delay flop on one asynchronous input, giving
// single-cycle rise/fall strobes in the clk domain.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   sync_bit;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset) sync_q[gi] <= 1'b0;
          else       sync_q[gi] <= sig_i;
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge reset) begin
          if (reset) sync_q[gi] <= 1'b0;
          else       sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dly_q <= 1'b0;
    else       dly_q <= sync_bit;
  end

  assign rise_o = sync_bit & ~dly_q;
  assign fall_o = ~sync_bit & dly_q;

endmodule

// File: rtl/period_meter.sv
// Measures rising-to-rising period of an asynchronous square wave in clk cycles.
// Define PERIOD_METER_HIGH_TIME_EN to also capture rising-to-falling high time.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int TIMEOUT_CYC = 12_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             rise;

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic             fall;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_q, high_d;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (sig_in),
    .rise_o (rise),
    .fall_o (fall)
  );
`else
  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (sig_in),
    .rise_o (rise),
    .fall_o ()
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // clear outranks everything, including a coincident rise or timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (clear) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      period_d  = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_MEASURE;
            cnt_d   = ONE_C;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = ONE_C;
          end else if (cnt_q == TIMEOUT_C) begin
            state_d   = ST_STALLED;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        ST_STALLED: begin
          // the resuming edge only re-arms; the next rise gives a valid period
          if (rise) begin
            state_d   = ST_MEASURE;
            cnt_d     = ONE_C;
            timeout_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_lat_q <= '0;
      high_q   <= '0;
    end else begin
      hi_lat_q <= hi_lat_d;
      high_q   <= high_d;
    end
  end

  // hi_lat stays 0 until a falling edge lands inside the current interval
  always_comb begin
    hi_lat_d = hi_lat_q;
    high_d   = high_q;
    if (clear) begin
      hi_lat_d = '0;
      high_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_STALLED: begin
          if (rise) hi_lat_d = '0;
        end
        ST_MEASURE: begin
          if (rise) begin
            high_d   = hi_lat_q;
            hi_lat_d = '0;
          end else if (fall) begin
            hi_lat_d = cnt_q;
          end
        end
        default: hi_lat_d = '0;
      endcase
    end
  end

  assign high_time = high_q;
`else
  assign high_time = '0;
`endif

  assign period       = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with a scoreboard of expected period/high-time pairs.
module tb_period_meter;

  localparam int CNT_W = 24;

  typedef struct packed {
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] h;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             sig_in;
  logic             clear;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             timeout;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;
  int   to_cyc = 0;
  bit   armed = 0;
  int   last_h = 0;
  int   last_l = 0;
  exp_t exp_q[$];

  period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (100),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sig_in       (sig_in),
    .clear        (clear),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .timeout      (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [CNT_W-1:0] exp_hi(input int h);
`ifdef PERIOD_METER_HIGH_TIME_EN
    return CNT_W'(h);
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One high/low cycle of sig_in; a measuring rise pushes the previous interval.
  task automatic pulse(input int h, input int l, input bit do_clear);
    if (!do_clear && armed)
      exp_q.push_back('{p: CNT_W'(last_h + last_l), h: exp_hi(last_h)});
    sig_in = 1'b1;
    if (do_clear) begin
      repeat (2) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      repeat (h - 3) @(negedge clk);
    end else begin
      repeat (h) @(negedge clk);
    end
    sig_in = 1'b0;
    repeat (l) @(negedge clk);
    armed  = !do_clear;
    last_h = h;
    last_l = l;
  endtask

  // Output monitor: pops the scoreboard on every valid pulse.
  initial begin
    bit   prev_valid;
    bit   prev_to;
    exp_t e;
    prev_valid = 1'b0;
    prev_to    = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_valid = 1'b0;
        prev_to    = 1'b0;
      end else begin
        if (period_valid) begin
          tests++;
          assert (!prev_valid) else begin
            fails++;
            $error("FAIL valid_width: observed 2+ cycles expected 1 at cycle %0d", cyc);
          end
          tests++;
          assert (exp_q.size() > 0) else begin
            fails++;
            $error("FAIL unexpected_valid: observed valid with period %0d expected none at cycle %0d", period, cyc);
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("period", period, e.p);
            chk("high_time", high_time, e.h);
            $display("[TB] cycle %0d valid period=%0d high_time=%0d", cyc, period, high_time);
          end
          last_valid_cyc = cyc;
        end
        if (timeout && !prev_to) to_cyc = cyc;
        prev_valid = period_valid;
        prev_to    = timeout;
      end
    end
  end

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    clear  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", period, '0);
    chk("rst_high_time", high_time, '0);
    chk("rst_valid", CNT_W'(period_valid), '0);
    chk("rst_timeout", CNT_W'(timeout), '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 5 high / 5 low
    repeat (6) pulse(5, 5, 1'b0);

    // 12 high / 8 low
    repeat (4) pulse(12, 8, 1'b0);

    // stall then resume
    pulse(5, 5, 1'b0);
    repeat (150) @(negedge clk);
    chk("timeout_set", CNT_W'(timeout), CNT_W'(1));
    chk("timeout_delay", CNT_W'(to_cyc - last_valid_cyc), CNT_W'(100));
    chk("period_held", period, CNT_W'(20));
    armed = 1'b0;
    pulse(5, 5, 1'b0);
    chk("timeout_clr", CNT_W'(timeout), '0);
    repeat (3) pulse(5, 5, 1'b0);

    // async reset mid-interval
    chk("pre_reset_period", period, CNT_W'(10));
    exp_q.push_back('{p: CNT_W'(10), h: exp_hi(5)});
    sig_in = 1'b1;
    repeat (5) @(negedge clk);
    sig_in = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_period", period, '0);
    chk("arst_high_time", high_time, '0);
    chk("arst_valid", CNT_W'(period_valid), '0);
    chk("arst_timeout", CNT_W'(timeout), '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    armed = 1'b0;
    repeat (3) pulse(5, 5, 1'b0);

    // clear coincident with a rise
    chk("pre_clear_period", period, CNT_W'(10));
    pulse(5, 5, 1'b1);
    chk("clear_period", period, '0);
    chk("clear_high_time", high_time, '0);
    chk("clear_timeout", CNT_W'(timeout), '0);
    repeat (3) pulse(5, 5, 1'b0);

    // minimum period
    repeat (8) pulse(1, 1, 1'b0);

    repeat (10) @(negedge clk);
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL missing_valid: observed %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
